// File: rtl/read_issuer_pkg.sv
// rtl/read_issuer_pkg.sv - shared state type and default sizing for the read issuer
package read_issuer_pkg;

  localparam int DEF_AW    = 8;
  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TMO   = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock request FIFO, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  // A push is refused whenever full, regardless of a same-cycle pop.
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;
  assign dout  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/read_issuer.sv
// rtl/read_issuer.sv - queues read requests, issues one at a time, returns data or timeout
module read_issuer
  import read_issuer_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TMO   = DEF_TMO
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          go,
  output logic [AW-1:0] addr,
  input  logic          ds,
  input  logic [DW-1:0] rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          proto_err
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_go;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_err;
  logic          r_proto_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_tmo;
  logic [AW-1:0] w_head;

  sync_fifo #(
    .WIDTH (AW),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (req_addr),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  // ds has priority over a timeout landing in the same cycle.
  assign w_done    = (r_state == WAIT) && ds;
  assign w_tmo     = (r_state == WAIT) && !ds && (r_cnt == TMO_C);
  assign w_pop     = w_done || w_tmo;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty && !r_rsp_valid) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_pop) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_go        <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_go <= (w_next == ISSUE);

      if ((r_state == IDLE) && (w_next == ISSUE)) begin
        r_addr <= w_head;
      end

      // Counter idles at zero outside WAIT and saturates at TMO.
      if (r_state != WAIT) begin
        r_cnt <= '0;
      end else if (r_cnt != TMO_C) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= rdata;
        r_rsp_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= '0;
        r_rsp_err   <= 1'b1;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      if (ds && (r_state != WAIT)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign go        = r_go;
  assign addr      = r_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_read_issuer.sv
// tb/tb_read_issuer.sv - directed self-checking bench for read_issuer
module tb_read_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic       go;
  logic [7:0] addr;
  logic       ds;
  logic [7:0] rdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       proto_err;

  int n_checks = 0;
  int n_errors = 0;
  int go_cnt   = 0;

  read_issuer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .go        (go),
    .addr      (addr),
    .ds        (ds),
    .rdata     (rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (go) go_cnt <= go_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_clear", rsp_valid, 0);
  endtask

  // Push a, see go after minimum latency, then ds in WAIT cycle nwait.
  task automatic txn(input logic [7:0] a, input int nwait, input logic [7:0] d);
    int base;
    base = go_cnt;
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
    check("lat_idle", go, 0);
    tick();
    check("go_issue", go, 1);
    check("addr_issue", addr, a);
    for (int i = 0; i < nwait; i++) tick();
    check("addr_hold", addr, a);
    check("no_rsp_yet", rsp_valid, 0);
    ds = 1'b1; rdata = d;
    tick();
    ds = 1'b0; rdata = 8'h00;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, d);
    check("rsp_err", rsp_err, 0);
    check("go_once", go_cnt - base, 1);
    check("proto_ok", proto_err, 0);
    consume();
  endtask

  // Wait (bounded) for the next go, check its address, complete in WAIT cycle 1.
  task automatic serve(input logic [7:0] exp_addr, input logic [7:0] d);
    int n;
    n = 0;
    while (!go && n < 20) begin
      tick();
      n++;
    end
    check("serve_go", go, 1);
    check("serve_addr", addr, exp_addr);
    tick();
    ds = 1'b1; rdata = d;
    tick();
    ds = 1'b0;
    check("serve_data", rsp_data, d);
    consume();
  endtask

  initial begin
    int base;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0;
    ds = 1'b0; rdata = '0; rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_req_ready", req_ready, 1);
    check("rst_go", go, 0);
    check("rst_addr", addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_proto", proto_err, 0);

    // Basic read, ds in third WAIT cycle.
    txn(8'h3C, 3, 8'hA5);

    // Seven wait-state cycles: single response, no further go.
    base = go_cnt;
    txn(8'h41, 7, 8'h5E);
    for (int i = 0; i < 4; i++) tick();
    check("one_rsp", rsp_valid, 0);
    check("no_extra_go", go_cnt - base, 1);

    // Five back-to-back pushes while the response is not consumed.
    base = go_cnt;
    req_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      req_addr = 8'(i);
      if (i == 5) begin
        check("full_rdy", req_ready, 0);
        ds = 1'b1; rdata = 8'h5A;
      end
      tick();
      if (i == 4) check("full_after4", req_ready, 0);
    end
    req_valid = 1'b0; ds = 1'b0;
    check("bb_rsp_valid", rsp_valid, 1);
    check("bb_rsp_data", rsp_data, 8'h5A);
    check("bb_ready_after_pop", req_ready, 1);
    for (int i = 0; i < 5; i++) tick();
    check("bb_held", rsp_valid, 1);
    check("bb_data_stable", rsp_data, 8'h5A);
    check("bb_no_second_go", go_cnt - base, 1);
    consume();
    serve(8'h02, 8'h12);
    serve(8'h03, 8'h13);
    serve(8'h04, 8'h14);
    base = go_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("bb_fifth_refused", go_cnt - base, 0);

    // Timeout: no ds for the first entry, second entry then issues.
    base = go_cnt;
    rdata = 8'hFF;
    req_valid = 1'b1; req_addr = 8'h11;
    tick();
    req_addr = 8'h22;
    tick();
    req_valid = 1'b0;
    check("tmo_go", go, 1);
    check("tmo_addr", addr, 8'h11);
    for (int i = 0; i < 15; i++) tick();
    check("tmo_not_yet15", rsp_valid, 0);
    tick();
    check("tmo_not_yet16", rsp_valid, 0);
    tick();
    check("tmo_valid", rsp_valid, 1);
    check("tmo_err", rsp_err, 1);
    check("tmo_data", rsp_data, 0);
    check("tmo_go_once", go_cnt - base, 1);
    consume();
    tick();
    check("tmo_next_go", go, 1);
    check("tmo_next_addr", addr, 8'h22);
    tick();
    ds = 1'b1; rdata = 8'h99;
    tick();
    ds = 1'b0;
    check("tmo_next_err", rsp_err, 0);
    check("tmo_next_data", rsp_data, 8'h99);
    consume();

    // ds on the cycle the counter reaches TMO wins.
    txn(8'h5C, 16, 8'hC3);

    // Reset in WAIT, then a stray ds.
    req_valid = 1'b1; req_addr = 8'h77;
    tick();
    req_valid = 1'b0;
    tick();
    check("rw_go", go, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_go0", go, 0);
    check("rw_addr0", addr, 0);
    check("rw_valid0", rsp_valid, 0);
    check("rw_data0", rsp_data, 0);
    check("rw_err0", rsp_err, 0);
    check("rw_proto0", proto_err, 0);
    check("rw_ready", req_ready, 1);
    tick();
    ds = 1'b1; rdata = 8'hEE;
    tick();
    ds = 1'b0;
    check("rw_proto1", proto_err, 1);
    check("rw_no_rsp", rsp_valid, 0);
    check("rw_no_go", go, 0);
    tick();
    tick();
    check("rw_proto_sticky", proto_err, 1);
    check("rw_still_no_rsp", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/read_issuer.md
READ_ISSUER -- requirements
Module: read_issuer

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning read-data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning request FIFO entries (power of two, >=2).
REQ-004 The block SHALL have parameter TMO, default 15, meaning WAIT-state cycles allowed before timeout.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, width 1: the single clock, all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-008 The block SHALL have port req_valid, input, width 1: request offered.
REQ-009 The block SHALL have port req_ready, output, width 1: request accepted this cycle when high with req_valid.
REQ-010 The block SHALL have port req_addr, input, width AW: request address.
REQ-011 The block SHALL have port go, output, width 1: start pulse to the downstream read controller.
REQ-012 The block SHALL have port addr, output, width AW: address of the transaction in flight.
REQ-013 The block SHALL have port ds, input, width 1: done strobe from the controller.
REQ-014 The block SHALL have port rdata, input, width DW: bus data, valid in the ds cycle.
REQ-015 The block SHALL have port rsp_valid, output, width 1: response held.
REQ-016 The block SHALL have port rsp_ready, input, width 1: response consumed.
REQ-017 The block SHALL have port rsp_data, output, width DW: captured data.
REQ-018 The block SHALL have port rsp_err, output, width 1: response was a timeout.
REQ-019 The block SHALL have port proto_err, output, width 1: sticky flag, ds seen outside WAIT.

Function
REQ-020 Request FIFO: req_ready SHALL equal !full; push on req_valid&&req_ready; a push is refused when full, even if a pop occurs in the same cycle.
REQ-021 The FSM SHALL have states IDLE, ISSUE and WAIT; go SHALL be registered and high only in ISSUE.
REQ-022 IDLE->ISSUE SHALL occur when the FIFO is non-empty and rsp_valid=0; otherwise the FSM SHALL stay in IDLE.
REQ-023 ISSUE->WAIT SHALL occur unconditionally after one cycle, so go is exactly one cycle wide.
REQ-024 addr SHALL be loaded from the FIFO head on entry to ISSUE and held stable until WAIT exits.
REQ-025 In WAIT with ds=1: rsp_data<=rdata, rsp_err<=0, rsp_valid<=1, FIFO pop, and ->IDLE.
REQ-026 The WAIT cycle counter SHALL clear on entry to WAIT; when it reaches TMO with ds=0: rsp_data<=0, rsp_err<=1, rsp_valid<=1, FIFO pop, and ->IDLE.
REQ-027 If ds=1 in the same cycle the counter reaches TMO, ds SHALL win (normal response).
REQ-028 The counter SHALL be $clog2(TMO+1) bits wide and saturate; it SHALL never wrap.
REQ-029 rsp_valid SHALL hold, with rsp_data and rsp_err stable, until rsp_valid&&rsp_ready; it SHALL clear on that edge.
REQ-030 ds=1 in IDLE or ISSUE SHALL set proto_err, which clears only on reset; the stray ds SHALL otherwise be ignored.
REQ-031 Minimum latency: a push at edge t SHALL give go=1 in the cycle after edge t+1, and a response cycles after ds.

Reset
REQ-032 On reset=1 at a clock edge: FSM=IDLE, FIFO empty, counter=0, go=0, addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, proto_err=0.
REQ-033 req_ready SHALL be 1 in the cycle after reset.
REQ-034 Reset mid-WAIT SHALL abandon the transaction with no response, and a later ds SHALL set proto_err.

Structure
REQ-035 Package read_issuer_pkg SHALL hold the state enum typedef and the default AW, DW, DEPTH and TMO constants.
REQ-036 The FIFO SHALL be sub-module sync_fifo (parameters: width, depth; ports: push, pop, din, dout, full, empty).

Verification
REQ-037 The bench SHALL cover: push addr 0x3C, controller returns ds after 3 cycles with rdata 0xA5 -> go one cycle, addr=0x3C, rsp_data=0xA5, rsp_err=0.
REQ-038 The bench SHALL cover: controller looping twice on wait-state (ds at 7 cycles) -> no timeout, one response, go pulsed once.
REQ-039 The bench SHALL cover: 5 back-to-back pushes with rsp_ready=0 -> req_ready=0 after the 4th accept, one response held, no second go.
REQ-040 The bench SHALL cover: ds never asserted -> after 15 WAIT cycles, rsp_err=1, rsp_data=0; next FIFO entry issues.
REQ-041 The bench SHALL cover: ds on the exact TMO cycle -> rsp_err=0, data captured.
REQ-042 The bench SHALL cover: reset asserted during WAIT, ds two cycles later -> all outputs 0 and proto_err=1.
